alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; all data ports are XLEN bits wide. Only 32 needs to be supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 A  input  XLEN  operand 1 (rs1).
REQ-005 B  input  XLEN  operand 2 (rs2 or immediate).
REQ-006 ALU_control  input  4  operation select.
REQ-007 PC  input  XLEN  program counter of the current instruction.
REQ-008 result  output  XLEN  registered operation result.
REQ-009 zero  output  1  registered flag, 1 when result is all zeros.

Function
REQ-010 The ALU SHALL compute combinationally from A, B, ALU_control and PC, then register the value into result on every rising clk edge; latency is exactly 1 cycle and there is no handshake or enable.
REQ-011 The ALU SHALL register zero in the same edge as result, with zero = (next result == 0), so the two outputs are always consistent.
REQ-012 Opcode map:
- 0000 ADD: A+B
- 0001 SUB: A-B
- 0010 AND: A&B
- 0011 OR: A|B
- 0100 XOR: A^B
- 0101 SLL: A << B[4:0]
- 0110 SRL: A >> B[4:0], logical
- 0111 SRA: A >> B[4:0], arithmetic
- 1000 SLT: signed A<B ? 1 : 0
- 1001 SLTU: unsigned A<B ? 1 : 0
- 1010 LUI: B
- 1011 AUIPC: PC+B
- 1100 JAL: PC+4 (link address)
- 1101 JALR: (A+B) with bit 0 cleared
- 1110 and 1111: 0
REQ-013 All additions and subtractions SHALL be modulo 2^XLEN; carry and overflow are discarded and there are no flags other than zero.
REQ-014 Shift amounts SHALL use only B[4:0]; bits B[31:5] are ignored.
REQ-015 The LUI opcode SHALL ignore A and PC, JAL SHALL ignore A and B, and AUIPC SHALL ignore A.
REQ-016 Any input change SHALL be reflected at the outputs only after the next rising clk edge.

Reset
REQ-017 While rst_n=0, result SHALL be 0 and zero SHALL be 1, asserted immediately and independently of clk.
REQ-018 After rst_n deasserts, the first rising edge SHALL load the value computed from the current inputs.
REQ-019 Reset asserted mid-stream SHALL discard the pending result with no residual state, because the block has no other state.

Configuration
REQ-020 Macro ALU_SHIFT_EN:
- When defined, opcodes 0101/0110/0111 behave per REQ-012.
- When undefined, those opcodes produce result 0 (zero=1) and no shifter logic is synthesised.
- All other opcodes are unaffected either way.

Verification
REQ-021 ADD A=10, B=5 -> after 1 edge, result=15, zero=0.
REQ-022 SUB A=10, B=5 -> result=5, zero=0; SUB A=5, B=5 -> result=0, zero=1.
REQ-023 LUI B=0x12345000, A=0 -> result=0x12345000; AUIPC PC=100, B=0x00001000 -> result=0x00001064.
REQ-024 JAL PC=200, B=4 -> result=204; JALR A=0, B=8 -> result=8; JALR A=0x101, B=0 -> result=0x100.
REQ-025 SRA A=0x80000000, B=0x21 -> result=0xC0000000 with ALU_SHIFT_EN defined, 0 without it; SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-026 Drive rst_n low between clk edges while result=15 -> result=0 and zero=1 immediately; release -> the next edge loads the current operation.

Source files
------------

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit -- single-cycle registered integer ALU (RV32I-style operations)
//
// Purpose:
//   Computes one operation from A, B and PC combinationally and registers the
//   value into result on every rising clk edge (latency exactly one cycle,
//   no handshake). zero is registered on the same edge and equals
//   (result == 0), so the two outputs can never disagree.
//
// Configuration:
//   ALU_SHIFT_EN -- when defined, opcodes 0101/0110/0111 perform SLL/SRL/SRA
//                   using B[4:0]. When undefined these opcodes yield 0 and no
//                   shifter is built. Other opcodes are unaffected.
//
// Ports:
//   clk          in   1     clock, rising edge
//   rst_n        in   1     asynchronous active-low reset (result=0, zero=1)
//   A            in   XLEN  operand 1 (rs1)
//   B            in   XLEN  operand 2 (rs2 or immediate)
//   ALU_control  in   4     operation select
//   PC           in   XLEN  program counter of the current instruction
//   result       out  XLEN  registered result
//   zero         out  1     registered flag, 1 when result is all zeros
// -----------------------------------------------------------------------------
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALU_control,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_LUI   = 4'b1010;
  localparam logic [3:0] OP_AUIPC = 4'b1011;
  localparam logic [3:0] OP_JAL   = 4'b1100;
  localparam logic [3:0] OP_JALR  = 4'b1101;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] result_next;

  // A+B is shared by ADD and JALR; carries out of the top bit are dropped.
  assign sum = A + B;

`ifdef ALU_SHIFT_EN
  logic [4:0] shamt;
  // Only the low five bits of B select the shift distance.
  assign shamt = B[4:0];
`endif

  always_comb begin
    result_next = '0;
    unique case (ALU_control)
      OP_ADD:   result_next = sum;
      OP_SUB:   result_next = A - B;
      OP_AND:   result_next = A & B;
      OP_OR:    result_next = A | B;
      OP_XOR:   result_next = A ^ B;
`ifdef ALU_SHIFT_EN
      OP_SLL:   result_next = A << shamt;
      OP_SRL:   result_next = A >> shamt;
      OP_SRA:   result_next = $unsigned($signed(A) >>> shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: result_next = '0;
`endif
      OP_SLT:   result_next = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:  result_next = {{(XLEN-1){1'b0}}, (A < B)};
      OP_LUI:   result_next = B;
      OP_AUIPC: result_next = PC + B;
      OP_JAL:   result_next = PC + XLEN'(4);
      // Jump target: bit 0 is forced low.
      OP_JALR:  result_next = {sum[XLEN-1:1], 1'b0};
      default:  result_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= result_next;
      zero   <= (result_next == '0);
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit -- scoreboard bench for alu_unit.
// Stimulus is applied on the falling edge and the expected response is pushed
// into a queue; a monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] pc;
  logic [31:0] result;
  logic        zero;

  alu_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (a),
    .B           (b),
    .ALU_control (op),
    .PC          (pc),
    .result      (result),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] exp;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  // Reference model: arithmetic on wide integers, truncated to 32 bits.
  function automatic logic [31:0] ref_model(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] p);
    longint unsigned ux  = x;
    longint unsigned uy  = y;
    longint unsigned up  = p;
    longint          sx  = longint'($signed(x));
    longint          sy  = longint'($signed(y));
    int unsigned     sh  = y % 32;
    longint unsigned pw  = 64'd1 << sh;   // 2**shift
    longint unsigned m32 = 64'h1_0000_0000;
    longint unsigned t;
    case (o)
      4'd0:  return 32'((ux + uy) % m32);
      4'd1:  return 32'((ux + m32 - uy) % m32);
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return SHIFT_EN ? 32'((ux * pw) % m32) : 32'd0;
      4'd6:  return SHIFT_EN ? 32'(ux / pw) : 32'd0;
      4'd7: begin
        // floor division of the signed value by 2**shift
        if (!SHIFT_EN) return 32'd0;
        if (sx >= 0) return 32'(sx / longint'(pw));
        return 32'(-((-sx + longint'(pw) - 1) / longint'(pw)));
      end
      4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (ux < uy) ? 32'd1 : 32'd0;
      4'd10: return y;
      4'd11: return 32'((up + uy) % m32);
      4'd12: return 32'((up + 4) % m32);
      4'd13: begin
        t = (ux + uy) % m32;
        return 32'(t - (t % 2));
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] p);
    txn_t t;
    @(negedge clk);
    op = o; a = x; b = y; pc = p;
    t.op = o; t.a = x; t.b = y; t.pc = p;
    t.exp = ref_model(o, x, y, p);
    exp_q.push_back(t);
  endtask

  // Monitor: one registered result per rising edge.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        n_txn++;
        n_checks++;
        if (result !== t.exp || zero !== (t.exp == 32'd0)) begin
          n_fail++;
          $display("FAIL txn%0d op=%h a=%h b=%h pc=%h: result=%h zero=%b, required result=%h zero=%b",
                   n_txn, t.op, t.a, t.b, t.pc, result, zero, t.exp, (t.exp == 32'd0));
        end else begin
          $display("txn%0d op=%h a=%h b=%h pc=%h result=%h zero=%b ok",
                   n_txn, t.op, t.a, t.b, t.pc, result, zero);
        end
      end
    end
  end

  task automatic check_direct(input string name, input logic [31:0] exp_r, input logic exp_z);
    n_checks++;
    if (result !== exp_r || zero !== exp_z) begin
      n_fail++;
      $display("FAIL %s: result=%h zero=%b, required result=%h zero=%b",
               name, result, zero, exp_r, exp_z);
    end else begin
      $display("%s: result=%h zero=%b ok", name, result, zero);
    end
  endtask

  // Directed vectors: op, A, B, PC
  localparam int ND = 20;
  logic [3:0]  d_op [ND] = '{4'd0, 4'd1, 4'd1, 4'd10, 4'd11, 4'd12, 4'd13, 4'd13,
                             4'd7, 4'd8, 4'd9, 4'd14, 4'd15, 4'd5, 4'd6, 4'd7,
                             4'd0, 4'd2, 4'd3, 4'd4};
  logic [31:0] d_a  [ND] = '{32'd10, 32'd10, 32'd5, 32'd0, 32'hDEADBEEF, 32'h1234, 32'd0, 32'h101,
                             32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF, 32'h1, 32'h8000_0001, 32'h8000_0000, 32'h7000_0000,
                             32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0F0F0000, 32'hAAAA5555};
  logic [31:0] d_b  [ND] = '{32'd5, 32'd5, 32'd5, 32'h12345000, 32'h00001000, 32'd4, 32'd8, 32'd0,
                             32'h21, 32'd1, 32'd1, 32'h1, 32'h2, 32'hFFFF_FFE1, 32'h1F, 32'h4,
                             32'd1, 32'h0FF00FF0, 32'h00000F0F, 32'hAAAA5555};
  logic [31:0] d_pc [ND] = '{32'd0, 32'd0, 32'd0, 32'h777, 32'd100, 32'd200, 32'h55, 32'h66,
                             32'd0, 32'd0, 32'd0, 32'h10, 32'h20, 32'd0, 32'd0, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'd0};

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    op = 4'd0; a = '0; b = '0; pc = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_direct("reset_async", 32'd0, 1'b1);
    // Nonzero inputs while reset is held must not leak through.
    op = 4'd0; a = 32'd3; b = 32'd4;
    repeat (2) @(posedge clk);
    #1 check_direct("reset_held", 32'd0, 1'b1);

    // Release on a falling edge; the first rising edge loads current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 32'd3, 32'd4, 32'd0);

    for (int i = 0; i < ND; i++) issue(d_op[i], d_a[i], d_b[i], d_pc[i]);

    // Mid-stream reset between edges while result=15.
    issue(4'd0, 32'd10, 32'd5, 32'd0);
    @(posedge clk);
    #3 check_direct("pre_reset_add", 32'd15, 1'b0);
    rst_n = 1'b0;
    #1 check_direct("mid_reset", 32'd0, 1'b1);
    op = 4'd1; a = 32'd9; b = 32'd2;
    @(posedge clk);
    #1 check_direct("mid_reset_held", 32'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      txn_t t;
      t.op = op; t.a = a; t.b = b; t.pc = pc;
      t.exp = ref_model(op, a, b, pc);
      exp_q.push_back(t);
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;                              // equal operands
        1: rb = $urandom_range(0, 40);           // small shift / compare values
        2: ra = {1'b1, ra[30:0]};                // negative A
        default: ;
      endcase
      issue(4'($urandom_range(0, 15)), ra, rb, $urandom);
    end

    // Drain with a bounded wait.
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
